// File: rtl/noc_serial_pkg.sv
// Shared definitions for the inter-router serial link transmitter and receiver.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a. Honours SERIAL_TX_PARITY_EN when sizing the frame.
package noc_serial_pkg;

  // Line levels: a frame opens with a high start bit, the idle line is low.
  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  // Transmitter sequencing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Number of line cycles one frame occupies: start bit, data bits and,
  // when enabled, one trailing even-parity bit.
  function automatic int frame_len(input int width);
`ifdef SERIAL_TX_PARITY_EN
    return width + 2;
`else
    return width + 1;
`endif
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with occupancy count, shared by the serial transmitter and receiver.
// Latency: a pushed entry is visible at pop_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full does not see same-cycle pops.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter: queues flits, sends each LSB-first behind a start bit, then idles GAP_CYCLES.
// Latency: push at edge N, launch at edge N+1, start bit on the line the cycle after; SERIAL_TX_PARITY_EN adds a parity bit.
// Backpressure: in_ready = !full (no ready-through); channel_busy only defers launch, never a frame in flight.
module serial_tx_fifo
  import noc_serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int ROUTERID   = -1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     channel_busy,
  output logic                     serial_out,
  output logic                     tx_active,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [FRAME_LEN-1:0] load_frame;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 active_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     head_data;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 shift_en;
  logic                 frame_done;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Frame image, bit 0 leaves first: start bit, data LSB-first, optional even parity last.
`ifdef SERIAL_TX_PARITY_EN
  assign load_frame = {^head_data, head_data, START_BIT};
`else
  assign load_frame = {head_data, START_BIT};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; launch is only decided from IDLE.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !channel_busy) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          frame_done = 1'b1;
          state_nxt  = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          shift_en = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and gap counter; the register is cleared at frame end so the line idles low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= {FRAME_LEN{IDLE_LEVEL}};
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      active_q  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_frame;
      bit_cnt   <= LAST_BIT;
      active_q  <= 1'b1;
    end else if (shift_en) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= bit_cnt - 1'b1;
    end else if (frame_done) begin
      shift_reg <= {FRAME_LEN{IDLE_LEVEL}};
      gap_cnt   <= GAP_LOAD;
      active_q  <= 1'b0;
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Both terms are flop outputs, so the line cannot glitch on a state change.
  assign tx_active  = active_q;
  assign serial_out = shift_reg[0] & active_q;
  assign tx_busy    = active_q | channel_busy | ~fifo_empty;

`ifndef SYNTHESIS
  if (ROUTERID >= 0) begin : g_trace
    // Launch trace for simulation logs.
    always @(posedge clk) begin
      if (reset && load) $display("router %d tx : %d", ROUTERID, head_data);
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo at WIDTH=8, DEPTH=4, GAP_CYCLES=1.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every comparison goes through check(); summary line reports totals.
module tb_serial_tx_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = WIDTH + 2;
`else
  localparam int FL = WIDTH + 1;
`endif
  localparam int PERIOD = FL + GAP_CYCLES + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             channel_busy;
  logic             serial_out;
  logic             tx_active;
  logic             tx_busy;
  logic [2:0]       fifo_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int last_launch = 0;

  logic [8:0] a5_seq;
  logic [9:0] x07_seq;

  serial_tx_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .ROUTERID   (-1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .tx_active    (tx_active),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_launch(input int budget);
    int n;
    n = 0;
    while (!tx_active && n < budget) begin
      tick();
      n++;
    end
    check("launch_seen", tx_active, 1);
  endtask

  // Expected line image: start bit, data LSB-first, optional even parity.
  task automatic expect_frame(input logic [WIDTH-1:0] d, input int first);
    logic [FL-1:0] f;
`ifdef SERIAL_TX_PARITY_EN
    f = {^d, d, 1'b1};
`else
    f = {d, 1'b1};
`endif
    for (int i = first; i < FL; i++) begin
      check($sformatf("frame_%02h_bit%0d", d, i), serial_out, f[i]);
      check($sformatf("frame_%02h_active%0d", d, i), tx_active, 1);
      tick();
    end
    check($sformatf("frame_%02h_end_active", d), tx_active, 0);
    check($sformatf("frame_%02h_end_line", d), serial_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    a5_seq       = 9'b101001011;
    x07_seq      = 10'b1000001111;
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    channel_busy = 1'b0;
    #12;

    // Reset state
    check("rst_serial_out", serial_out, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_busy_free", tx_busy, 0);
    channel_busy = 1'b1;
    #1;
    check("rst_tx_busy_chan", tx_busy, 1);
    channel_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single flit 0xA5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("a5_count_after_push", fifo_count, 1);
    check("a5_not_yet_active", tx_active, 0);
    tick();
    check("a5_count_after_pop", fifo_count, 0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("a5_bit%0d", i), serial_out, a5_seq[i]);
      check($sformatf("a5_active%0d", i), tx_active, 1);
      check($sformatf("a5_busy%0d", i), tx_busy, 1);
      tick();
    end
`ifdef SERIAL_TX_PARITY_EN
    check("a5_parity", serial_out, 0);
    check("a5_parity_active", tx_active, 1);
    tick();
`endif
    check("a5_gap_line", serial_out, 0);
    check("a5_gap_active", tx_active, 0);
    tick();
    check("a5_idle_line", serial_out, 0);
    check("a5_idle_active", tx_active, 0);
    check("a5_idle_count", fifo_count, 0);
    check("a5_idle_tx_busy", tx_busy, 0);

    // Fill while the channel is busy
    channel_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      tick();
      if (k == 4) begin
        check("fill_ready_low", in_ready, 0);
        check("fill_count4", fifo_count, 4);
      end
    end
    check("full_hold_count", fifo_count, 4);
    check("full_hold_ready", in_ready, 0);
    check("full_line_idle", serial_out, 0);
    check("full_no_tx", tx_active, 0);
    check("full_tx_busy", tx_busy, 1);

    // Release: 0x01 launches, 0x05 enters as soon as a slot frees
    channel_busy = 1'b0;
    tick();
    check("rel_active", tx_active, 1);
    check("rel_count", fifo_count, 3);
    check("rel_ready", in_ready, 1);
    check("rel_start_bit", serial_out, 1);
    last_launch = cyc;
    tick();
    in_valid = 1'b0;
    check("flit5_accepted", fifo_count, 4);
    expect_frame(8'h01, 1);
    for (int k = 2; k <= 5; k++) begin
      wait_launch(PERIOD + 4);
      check($sformatf("spacing_%0d", k), cyc - last_launch, PERIOD);
      last_launch = cyc;
      expect_frame(8'(k), 0);
    end
    check("drain_count", fifo_count, 0);

    // channel_busy raised during a frame does not disturb it
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_data  = 8'h11;
    tick();
    in_valid = 1'b0;
    check("ff_launched", tx_active, 1);
    check("ff_queued_one", fifo_count, 1);
    channel_busy = 1'b1;
    expect_frame(8'hFF, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_active%0d", i), tx_active, 0);
      check($sformatf("hold_count%0d", i), fifo_count, 1);
      tick();
    end
    channel_busy = 1'b0;
    wait_launch(4);
    check("x11_count", fifo_count, 0);
    expect_frame(8'h11, 0);

    // Reset during the 4th bit with two flits queued
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    in_data  = 8'h42;
    tick();
    check("x81_launched", tx_active, 1);
    in_data  = 8'h24;
    tick();
    in_valid = 1'b0;
    check("x81_queued_two", fifo_count, 2);
    tick();
    tick();
    check("x81_mid_active", tx_active, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_line", serial_out, 0);
    check("midrst_active", tx_active, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    check("postrst_idle", tx_active, 0);
    check("postrst_count", fifo_count, 0);

    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    check("x3c_count", fifo_count, 1);
    check("x3c_wait", tx_active, 0);
    tick();
    check("x3c_latency", tx_active, 1);
    expect_frame(8'h3C, 0);

`ifdef SERIAL_TX_PARITY_EN
    // Odd-weight data gets a high parity bit
    in_valid = 1'b1;
    in_data  = 8'h07;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("x07_bit%0d", i), serial_out, x07_seq[i]);
      check($sformatf("x07_active%0d", i), tx_active, 1);
      tick();
    end
    check("x07_end_active", tx_active, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- Parametrised successor to the single-flit serial transmitter.
- Accepts WIDTH-bit flits through a valid/ready port into a DEPTH-entry FIFO.
- Serialises each flit LSB-first behind a start bit and enforces a configurable idle gap between frames.
- Defers frame launch while the downstream channel reports busy. Sits between router output-port arbitration and the inter-router serial link.

Parameters:
- WIDTH, 8, flit data width in bits (>=1).
- DEPTH, 4, FIFO entries (power of two, >=2).
- GAP_CYCLES, 1, idle-low cycles forced after every frame (0 allowed).
- ROUTERID, -1, router id for simulation trace; trace disabled when <0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  flit offered on in_data.
- in_data  input  WIDTH  flit payload.
- in_ready  output  1  FIFO can accept; equals !full.
- channel_busy  input  1  downstream link unavailable; blocks frame launch only.
- serial_out  output  1  serial line; 0 when idle.
- tx_active  output  1  frame currently on the line (start, data, optional parity bits).
- tx_busy  output  1  tx_active | channel_busy | FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async): FIFO empty, state IDLE, shift register 0, bit counter 0. Outputs: serial_out=0, tx_active=0, in_ready=1, fifo_count=0, tx_busy=channel_busy.
- Push: occurs on a clk edge with in_valid&in_ready; fifo_count increments that edge.
- Full: in_ready=0 when fifo_count==DEPTH, even if a pop happens the same cycle. There is no combinational ready-through path.
- Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo DEPTH.
- IDLE state:
  - If FIFO non-empty and channel_busy==0 at an edge: pop head, load shift register {data, 1'b1}, enter SHIFT, tx_active=1 from that edge.
  - If channel_busy==1, stay in IDLE; no pop occurs.
- SHIFT state:
  - serial_out = shift_reg[0] & tx_active, registered source, no glitch path.
  - Shift right once per cycle. Frame = start bit 1, then WIDTH data bits LSB-first: WIDTH+1 cycles.
  - channel_busy is ignored once SHIFT is entered.
- Last frame bit: on its final cycle, at the next edge tx_active=0, serial_out=0. Enter GAP if GAP_CYCLES>0, else IDLE.
- GAP state: line held 0 for GAP_CYCLES cycles, then IDLE. The next launch decision is made on the IDLE cycle.
- Latency: flit pushed at edge N (FIFO empty, idle, channel free) -> popped at edge N+1 -> start bit driven in cycle after N+1.
- Back-to-back minimum frame period: WIDTH+1+GAP_CYCLES+1 cycles.
- Reset mid-frame: frame is truncated immediately, line forced 0, FIFO contents discarded.
- Trace: when ROUTERID>=0, $display at each launch: "router %d tx : %d" with the popped data. Simulation only.

Optional Feature:
- SERIAL_TX_PARITY_EN defined: one even-parity bit (XOR of data bits) is appended after the MSB. Frame becomes WIDTH+2 cycles; tx_active covers the parity bit.
- Macro undefined: no parity bit, frame is WIDTH+1 cycles, and no parity logic is synthesised.

Decomposition:
- Shared package noc_serial_pkg holds:
  - START_BIT=1'b1 and IDLE_LEVEL=1'b0.
  - The state encoding enum {IDLE, SHIFT, GAP}.
  - A frame_len(WIDTH) constant function that accounts for SERIAL_TX_PARITY_EN.
- One sub-module: tx_fifo (synchronous FIFO with push/pop, full, empty, count). It is reusable by the matching receiver.

Test Plan (WIDTH=8, DEPTH=4, GAP_CYCLES=1):
- Single flit 0xA5, channel free -> serial_out over successive cycles 1,1,0,1,0,0,1,0,1; tx_active high for exactly those 9 cycles; then 1 gap cycle at 0; fifo_count back to 0.
- Push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with channel_busy=1 -> in_ready drops after the 4th push; 0x05 is held off; fifo_count=4; serial_out stays 0.
- Release channel_busy -> frames for 0x01..0x04 sent in order, 11 cycles apart; 0x05 accepted once in_ready rises.
- Assert channel_busy during a frame of 0xFF -> frame completes unaltered; the next queued flit waits until channel_busy=0.
- Assert reset low at the 4th bit of a frame with 2 flits queued -> serial_out=0, tx_active=0, fifo_count=0 immediately; after release, a new push of 0x3C transmits correctly.
- With SERIAL_TX_PARITY_EN, send 0xA5 -> parity bit 0 appended (10 active cycles); send 0x07 -> parity bit 1.
